// File: rtl/bft_pkg.sv
// Shared definitions for the BFT pi/t leaf logic: link direction codes and
// the leaf injector state encoding.
package bft_pkg;

   // Switch port direction codes; UPL/UPR alias the two up-link halves.
   localparam logic [1:0] VOID  = 2'b00;
   localparam logic [1:0] LEFT  = 2'b01;
   localparam logic [1:0] RIGHT = 2'b10;
   localparam logic [1:0] UP    = 2'b11;
   localparam logic [1:0] UPL   = 2'b11;
   localparam logic [1:0] UPR   = 2'b00;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } inj_state_t;

endpackage

// File: rtl/bft_rr_pick.sv
// Rotating-priority encoder: returns the first asserted request at or after
// i_ptr, searching cyclically, plus an any-request flag.
module bft_rr_pick #(
   parameter int unsigned N     = 4,
   parameter int unsigned PTR_W = 2
) (
   input  logic [N-1:0]     i_req,
   input  logic [PTR_W-1:0] i_ptr,
   output logic [PTR_W-1:0] o_idx_c,
   output logic             o_any_req_c
);

   logic [PTR_W-1:0] w_cand;
   int               w_pos;

   // Walk from the farthest slot back to i_ptr so the closest request wins.
   always_comb begin
      o_idx_c     = '0;
      o_any_req_c = 1'b0;
      w_cand      = '0;
      w_pos       = 0;
      for (int k = int'(N) - 1; k >= 0; k--) begin
         w_pos = int'(i_ptr) + k;
         if (w_pos >= int'(N)) w_pos = w_pos - int'(N);
         w_cand = PTR_W'(w_pos);
         if (i_req[w_cand]) begin
            o_idx_c     = w_cand;
            o_any_req_c = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bft_leaf_injector.sv
// Leaf-port injector for the deflection-routed BFT: grants one local source at
// a time (round robin, bounded burst) into free switch slots.
// Optional statistics counters are enabled with BFT_INJECT_STATS_EN.
module bft_leaf_injector
   import bft_pkg::*;
#(
   parameter int unsigned NUM_SRC   = 4,
   parameter int unsigned PKT_W     = 49,
   parameter int unsigned BURST_MAX = 4,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_SRC-1:0]       src_valid,
   input  logic [NUM_SRC*PKT_W-1:0] src_data,
   output logic [NUM_SRC-1:0]       src_ready,
   input  logic                     net_slot_free,
   output logic                     out_valid,
   output logic [PKT_W-1:0]         out_pkt,
   output logic                     busy
`ifdef BFT_INJECT_STATS_EN
   ,
   output logic [NUM_SRC*CNT_W-1:0] inj_count,
   output logic [CNT_W-1:0]         stall_count
`endif
);

   localparam int unsigned PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int unsigned BC_W  = $clog2(BURST_MAX + 1);

   inj_state_t       r_state;
   logic [PTR_W-1:0] r_owner;
   logic [PTR_W-1:0] r_rr_ptr;
   logic [BC_W-1:0]  r_burst_cnt;

   logic [PTR_W-1:0] w_pick;
   logic             w_any_req;
   logic [PTR_W-1:0] w_next_ptr;
   logic [PKT_W-1:0] w_owner_data;
   logic             w_owner_valid;
   logic             w_in_burst;
   logic             w_xfer;
   logic             w_last_beat;

   bft_rr_pick #(
      .N     (NUM_SRC),
      .PTR_W (PTR_W)
   ) u_pick (
      .i_req       (src_valid),
      .i_ptr       (r_rr_ptr),
      .o_idx_c     (w_pick),
      .o_any_req_c (w_any_req)
   );

   // Reset gates the grant so no source sees ready while reset is asserted.
   assign w_in_burst  = (r_state == BURST) && !reset;
   assign w_next_ptr  = (r_owner == PTR_W'(NUM_SRC - 1)) ? '0 : r_owner + 1'b1;
   assign w_xfer      = w_in_burst && net_slot_free && w_owner_valid;
   assign w_last_beat = (r_burst_cnt == BC_W'(BURST_MAX - 1));
   assign busy        = (r_state == BURST);

   // Owner mux and one-hot ready; ready never looks at src_valid.
   always_comb begin
      w_owner_data  = '0;
      w_owner_valid = 1'b0;
      src_ready     = '0;
      for (int i = 0; i < int'(NUM_SRC); i++) begin
         if (r_owner == PTR_W'(i)) begin
            w_owner_data  = src_data[i*PKT_W +: PKT_W];
            w_owner_valid = src_valid[i];
            src_ready[i]  = w_in_burst && net_slot_free;
         end
      end
   end

   // Grant FSM with registered injection output.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_owner     <= '0;
         r_rr_ptr    <= '0;
         r_burst_cnt <= '0;
         out_valid   <= 1'b0;
         out_pkt     <= '0;
      end else begin
         out_valid <= w_xfer;
         if (w_xfer) out_pkt <= w_owner_data;

         case (r_state)
            IDLE: begin
               if (w_any_req) begin
                  r_owner     <= w_pick;
                  r_burst_cnt <= '0;
                  r_state     <= BURST;
               end
            end
            BURST: begin
               if (!w_owner_valid) begin
                  r_state  <= IDLE;
                  r_rr_ptr <= w_next_ptr;
               end else if (w_xfer) begin
                  r_burst_cnt <= r_burst_cnt + 1'b1;
                  if (w_last_beat) begin
                     r_state  <= IDLE;
                     r_rr_ptr <= w_next_ptr;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef BFT_INJECT_STATS_EN
   logic [CNT_W-1:0] r_inj_cnt [NUM_SRC];
   logic [CNT_W-1:0] r_stall_cnt;
   logic             w_stall;

   assign w_stall = w_in_burst && w_owner_valid && !net_slot_free;

   // Saturating per-source accept counters and a shared stall counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(NUM_SRC); i++) r_inj_cnt[i] <= '0;
         r_stall_cnt <= '0;
      end else begin
         for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (w_xfer && (r_owner == PTR_W'(i)) && (r_inj_cnt[i] != '1))
               r_inj_cnt[i] <= r_inj_cnt[i] + 1'b1;
         end
         if (w_stall && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   always_comb begin
      inj_count = '0;
      for (int i = 0; i < int'(NUM_SRC); i++)
         inj_count[i*CNT_W +: CNT_W] = r_inj_cnt[i];
   end

   assign stall_count = r_stall_cnt;
`endif

endmodule

// File: tb/tb_bft_leaf_injector.sv
// Directed self-checking bench for bft_leaf_injector (statistics checks are
// built when BFT_INJECT_STATS_EN is defined).
module tb_bft_leaf_injector;

   localparam int unsigned NS = 4;
   localparam int unsigned PW = 49;
   localparam int unsigned BM = 4;
   localparam int unsigned CW = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             nsf;
   logic [NS-1:0]    sv;
   logic [NS*PW-1:0] sd;
   logic [NS-1:0]    rdy;
   logic             ov;
   logic [PW-1:0]    opkt;
   logic             busy;
`ifdef BFT_INJECT_STATS_EN
   logic [NS*CW-1:0] inj;
   logic [CW-1:0]    stc;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   bft_leaf_injector #(
      .NUM_SRC   (NS),
      .PKT_W     (PW),
      .BURST_MAX (BM),
      .CNT_W     (CW)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .src_valid     (sv),
      .src_data      (sd),
      .src_ready     (rdy),
      .net_slot_free (nsf),
      .out_valid     (ov),
      .out_pkt       (opkt),
      .busy          (busy)
`ifdef BFT_INJECT_STATS_EN
      ,
      .inj_count     (inj),
      .stall_count   (stc)
`endif
   );

   function automatic logic [PW-1:0] pkt_of(input int i);
      return {1'b1, 16'(i * 16'h1111), 32'hC0DE_0000 + 32'(i)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      sv    = '0;
      nsf   = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      sv    = '1;
      nsf   = 1'b1;
      tick();
      tick();
      checks++; if (rdy !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b want=0000", rdy); end
      checks++; if (ov !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", ov); end
      checks++; if (opkt !== '0) begin failures++; $display("FAIL reset_out_pkt got=%h want=0", opkt); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
      reset = 1'b0;
      sv    = '0;
      tick();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_no_req_busy got=%b want=0", busy); end
      checks++; if (rdy !== 4'b0000) begin failures++; $display("FAIL idle_no_req_ready got=%b want=0000", rdy); end
   endtask

   task automatic test_single_source();
      bit eb [7] = '{1, 1, 1, 1, 0, 1, 1};
      bit eo [7] = '{0, 1, 1, 1, 1, 0, 1};
      logic [NS-1:0] er;
      do_reset();
      sv = 4'b0001;
      for (int k = 0; k < 7; k++) begin
         tick();
         er = eb[k] ? 4'b0001 : 4'b0000;
         checks++; if (busy !== eb[k]) begin failures++; $display("FAIL single_busy cyc=%0d got=%b want=%b", k + 1, busy, eb[k]); end
         checks++; if (rdy !== er) begin failures++; $display("FAIL single_ready cyc=%0d got=%b want=%b", k + 1, rdy, er); end
         checks++; if (ov !== eo[k]) begin failures++; $display("FAIL single_out_valid cyc=%0d got=%b want=%b", k + 1, ov, eo[k]); end
         if (eo[k]) begin
            checks++; if (opkt !== pkt_of(0)) begin failures++; $display("FAIL single_out_pkt cyc=%0d got=%h want=%h", k + 1, opkt, pkt_of(0)); end
         end
      end
      sv = '0;
   endtask

   task automatic test_round_robin();
      int phase;
      int own;
      logic [NS-1:0] er;
      logic eo;
      do_reset();
      sv = 4'b1111;
      for (int k = 1; k <= 22; k++) begin
         tick();
         phase = (k - 1) % 5;
         own   = ((k - 1) / 5) % 4;
         er    = (phase == 4) ? 4'b0000 : 4'(1 << own);
         eo    = (phase != 0);
         checks++; if (rdy !== er) begin failures++; $display("FAIL rr_ready cyc=%0d got=%b want=%b", k, rdy, er); end
         checks++; if (ov !== eo) begin failures++; $display("FAIL rr_out_valid cyc=%0d got=%b want=%b", k, ov, eo); end
         if (eo) begin
            checks++; if (opkt !== pkt_of(own)) begin failures++; $display("FAIL rr_out_pkt cyc=%0d got=%h want=%h", k, opkt, pkt_of(own)); end
         end
      end
      sv = '0;
   endtask

   task automatic test_stall();
      do_reset();
      sv  = 4'b0100;
      nsf = 1'b1;
      tick();
      checks++; if (rdy !== 4'b0100) begin failures++; $display("FAIL stall_grant_ready got=%b want=0100", rdy); end
      nsf = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++; if (rdy !== 4'b0000) begin failures++; $display("FAIL stall_ready cyc=%0d got=%b want=0000", k, rdy); end
         checks++; if (ov !== 1'b0) begin failures++; $display("FAIL stall_out_valid cyc=%0d got=%b want=0", k, ov); end
         checks++; if (busy !== 1'b1) begin failures++; $display("FAIL stall_busy cyc=%0d got=%b want=1", k, busy); end
      end
      nsf = 1'b1;
      for (int j = 0; j < 4; j++) begin
         tick();
         checks++; if (ov !== 1'b1) begin failures++; $display("FAIL stall_resume_valid pkt=%0d got=%b want=1", j, ov); end
         checks++; if (opkt !== pkt_of(2)) begin failures++; $display("FAIL stall_resume_pkt pkt=%0d got=%h want=%h", j, opkt, pkt_of(2)); end
         checks++; if (busy !== (j < 3)) begin failures++; $display("FAIL stall_resume_busy pkt=%0d got=%b want=%b", j, busy, (j < 3)); end
      end
      tick();
      checks++; if (ov !== 1'b0) begin failures++; $display("FAIL stall_gap_valid got=%b want=0", ov); end
      sv = '0;
   endtask

   task automatic test_drop_and_reset();
      do_reset();
      sv = 4'b1010;
      tick();
      checks++; if (rdy !== 4'b0010) begin failures++; $display("FAIL drop_grant_ready got=%b want=0010", rdy); end
      tick();
      tick();
      checks++; if (ov !== 1'b1 || opkt !== pkt_of(1)) begin failures++; $display("FAIL drop_second_pkt got=%b/%h want=1/%h", ov, opkt, pkt_of(1)); end
      sv = 4'b1001;
      tick();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL drop_release_busy got=%b want=0", busy); end
      checks++; if (ov !== 1'b0) begin failures++; $display("FAIL drop_release_valid got=%b want=0", ov); end
      tick();
      checks++; if (rdy !== 4'b1000) begin failures++; $display("FAIL drop_next_grant got=%b want=1000", rdy); end
      tick();
      checks++; if (ov !== 1'b1 || opkt !== pkt_of(3)) begin failures++; $display("FAIL drop_next_pkt got=%b/%h want=1/%h", ov, opkt, pkt_of(3)); end
      // Reset in the middle of owner 3's burst, with a packet pending.
      reset = 1'b1;
      #1;
      checks++; if (rdy !== 4'b0000) begin failures++; $display("FAIL midrst_ready_during got=%b want=0000", rdy); end
      tick();
      checks++; if (ov !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b want=0", ov); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b want=0", busy); end
      checks++; if (rdy !== 4'b0000) begin failures++; $display("FAIL midrst_ready got=%b want=0000", rdy); end
      reset = 1'b0;
      tick();
      checks++; if (rdy !== 4'b0001) begin failures++; $display("FAIL midrst_ptr_regrant got=%b want=0001", rdy); end
      sv = '0;
   endtask

`ifdef BFT_INJECT_STATS_EN
   task automatic test_stats();
      int pkts   = 0;
      int stalls = 0;
      int cyc    = 0;
      int mc     = 0;
      bit mb     = 1'b0;
      logic [CW-1:0] es;
      do_reset();
      sv = 4'b0001;
      while (pkts < 20 && cyc < 500) begin
         nsf = ((cyc % 5) != 2);
         if (mb) begin
            if (nsf) begin
               pkts++;
               mc++;
               if (mc == int'(BM)) mb = 1'b0;
            end else begin
               stalls++;
            end
         end else begin
            mb = 1'b1;
            mc = 0;
         end
         tick();
         cyc++;
      end
      checks++; if (cyc >= 500) begin failures++; $display("FAIL stats_timeout got=%0d want<500", cyc); end
      sv  = '0;
      nsf = 1'b1;
      tick();
      es = (stalls > 15) ? 4'hF : CW'(stalls);
      checks++; if (inj[CW-1:0] !== 4'hF) begin failures++; $display("FAIL stats_inj0 got=%0d want=15", inj[CW-1:0]); end
      checks++; if (inj[NS*CW-1:CW] !== '0) begin failures++; $display("FAIL stats_inj_other got=%h want=0", inj[NS*CW-1:CW]); end
      checks++; if (stc !== es) begin failures++; $display("FAIL stats_stall got=%0d want=%0d", stc, es); end
   endtask
`endif

   initial begin
      reset = 1'b1;
      sv    = '0;
      nsf   = 1'b1;
      for (int i = 0; i < int'(NS); i++) sd[i*PW +: PW] = pkt_of(i);
      test_reset();
      test_single_source();
      test_round_robin();
      test_stall();
      test_drop_and_reset();
`ifdef BFT_INJECT_STATS_EN
      test_stats();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
